// File: rtl/data_memory_controller.sv
// Byte-addressed data-memory controller for the CPU data port.
// Misaligned accesses that straddle a word boundary take a second access cycle.
package cpu_types;
   typedef enum logic [1:0] {
      MEM_BYTE     = 2'b00,
      MEM_HALFWORD = 2'b01,
      MEM_WORD     = 2'b10
   } memory_mask_t;
endpackage

module data_memory_controller
   import cpu_types::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req,
   input  logic         we,
   input  logic [31:0]  address,
   input  memory_mask_t mask,
   input  logic [31:0]  write_data,
   output logic [31:0]  read_data,
   output logic         ready,
   output logic         stall
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

   state_t       state;
   logic [31:0]  addr_q;
   logic [31:0]  wdata_q;
   logic         we_q;
   memory_mask_t mask_q;

   logic [31:0]  mem [DEPTH];

   logic [2:0]   size;
   logic [3:0]   offset;
   logic [3:0]   span;
   logic         crossing;
   logic         busy;
   logic [AW-1:0] widx;
   logic [31:0]  rword;
   logic [31:0]  rd_next;
   logic [3:0]   en;
   logic [7:0]   wbyte [4];

   assign stall = req & ~ready;

   always_comb begin
      case (mask_q)
         MEM_BYTE:     size = 3'd1;
         MEM_HALFWORD: size = 3'd2;
         MEM_WORD:     size = 3'd4;
         default:      size = 3'd0;
      endcase
   end

   assign offset   = {2'b00, addr_q[1:0]};
   assign span     = offset + {1'b0, size};
   assign crossing = span > 4'd4;
   assign busy     = (state == ACC0) || (state == ACC1);

   // ACC1 always targets the next word, wrapping at the top of storage
   assign widx  = addr_q[AW+1:2] + AW'(state == ACC1);
   assign rword = mem[widx];

   // Lane j of the word holds data byte idx; ACC1 continues after the ACC0 bytes
   always_comb begin
      logic [3:0] lane;
      logic [3:0] idx;
      en      = '0;
      rd_next = (state == ACC1) ? read_data : '0;
      for (int j = 0; j < 4; j++) begin
         lane = 4'(j);
         idx  = 4'd0;
         if (state == ACC0) begin
            en[j] = (lane >= offset) && (lane < span);
            idx   = lane - offset;
         end else if (state == ACC1) begin
            en[j] = (lane + 4'd4) < span;
            idx   = lane + 4'd4 - offset;
         end
         wbyte[j] = wdata_q[{idx[1:0], 3'b000} +: 8];
         if (en[j]) rd_next[{idx[1:0], 3'b000} +: 8] = rword[8*j +: 8];
      end
   end

   always_ff @(posedge clk) begin
      if (busy && we_q) begin
         for (int j = 0; j < 4; j++) begin
            if (en[j]) mem[widx][8*j +: 8] <= wbyte[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         ready     <= 1'b0;
         read_data <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         mask_q    <= MEM_BYTE;
      end else begin
         case (state)
            IDLE: begin
               ready <= 1'b0;
               if (req) begin
                  addr_q  <= address;
                  wdata_q <= write_data;
                  we_q    <= we;
                  mask_q  <= mask;
                  state   <= ACC0;
               end
            end
            ACC0: begin
               if (!we_q) read_data <= rd_next;
               state <= crossing ? ACC1 : RESP;
               ready <= ~crossing;
            end
            ACC1: begin
               if (!we_q) read_data <= rd_next;
               state <= RESP;
               ready <= 1'b1;
            end
            default: begin
               state <= IDLE;
               ready <= 1'b0;
            end
         endcase
      end
   end

endmodule
